// File: rtl/axi_arb_pkg.sv
// Shared FSM type and AXI3 encodings for the multi-master write-path arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping modulo NUM_MST.
module rr_arbiter #(
  parameter int NUM_MST = 2
) (
  input  logic [NUM_MST-1:0]         req,
  input  logic [$clog2(NUM_MST)-1:0] ptr,
  output logic [NUM_MST-1:0]         gnt_oh,
  output logic [$clog2(NUM_MST)-1:0] gnt_idx,
  output logic                       gnt_vld
);

  localparam int GW = $clog2(NUM_MST);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_MST; k++) begin
      if (!gnt_vld && req[(int'(ptr) + k) % NUM_MST]) begin
        gnt_vld                            = 1'b1;
        gnt_oh[(int'(ptr) + k) % NUM_MST]  = 1'b1;
        gnt_idx                            = GW'((int'(ptr) + k) % NUM_MST);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI3 write path among NUM_MST masters, one transaction at a time,
// with W/B locked to the AW winner until the write response completes.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MST-1:0]                m_awvalid,
  output logic [NUM_MST-1:0]                m_awready,
  input  logic [NUM_MST*ID_W-1:0]           m_awid,
  input  logic [NUM_MST*ADDR_W-1:0]         m_awaddr,
  input  logic [NUM_MST*LEN_W-1:0]          m_awlen,
  input  logic [NUM_MST*3-1:0]              m_awsize,
  input  logic [NUM_MST*2-1:0]              m_awburst,
  input  logic [NUM_MST-1:0]                m_wvalid,
  output logic [NUM_MST-1:0]                m_wready,
  input  logic [NUM_MST*DATA_W-1:0]         m_wdata,
  input  logic [NUM_MST*(DATA_W/8)-1:0]     m_wstrb,
  input  logic [NUM_MST-1:0]                m_wlast,
  output logic [NUM_MST-1:0]                m_bvalid,
  input  logic [NUM_MST-1:0]                m_bready,
  output logic [NUM_MST*ID_W-1:0]           m_bid,
  output logic [NUM_MST*2-1:0]              m_bresp,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ID_W-1:0]                   s_awid,
  output logic [ADDR_W-1:0]                 s_awaddr,
  output logic [LEN_W-1:0]                  s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [ID_W-1:0]                   s_wid,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  output logic                              s_wlast,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  input  logic [ID_W-1:0]                   s_bid,
  input  logic [1:0]                        s_bresp,
  output logic [$clog2(NUM_MST)-1:0]        grant,
  output logic                              busy,
  output logic                              err_wlast,
  output logic                              err_bid
);

  localparam int GW = $clog2(NUM_MST);
  localparam int SW = DATA_W / 8;

  state_e               state;
  logic [GW-1:0]        ptr;
  logic [NUM_MST-1:0]   grant_oh;
  logic [LEN_W-1:0]     beat_cnt;
  logic [ID_W-1:0]      wid_q;
  logic [NUM_MST-1:0]   arb_oh;
  logic [GW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 aw_hs, w_hs, b_hs;
  int                   gi;

  rr_arbiter #(.NUM_MST(NUM_MST)) u_rr (
    .req     (m_awvalid),
    .ptr     (ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign gi    = int'(grant);
  assign busy  = (state != IDLE);
  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  // Channel muxing: only the channel owned by the current state is routed; everything else idles at 0.
  always_comb begin
    s_awvalid = 1'b0;
    s_awid    = '0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_awsize  = '0;
    s_awburst = '0;
    s_wvalid  = 1'b0;
    s_wid     = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bid     = '0;
    m_bresp   = '0;
    case (state)
      ADDR: begin
        s_awvalid = m_awvalid[grant];
        s_awid    = m_awid[gi*ID_W +: ID_W];
        s_awaddr  = m_awaddr[gi*ADDR_W +: ADDR_W];
        s_awlen   = m_awlen[gi*LEN_W +: LEN_W];
        s_awsize  = m_awsize[gi*3 +: 3];
        s_awburst = m_awburst[gi*2 +: 2];
        m_awready = grant_oh & {NUM_MST{s_awready}};
      end
      DATA: begin
        s_wvalid = m_wvalid[grant];
        s_wid    = wid_q;
        s_wdata  = m_wdata[gi*DATA_W +: DATA_W];
        s_wstrb  = m_wstrb[gi*SW +: SW];
        s_wlast  = m_wlast[grant];
        m_wready = grant_oh & {NUM_MST{s_wready}};
      end
      RESP: begin
        s_bready = m_bready[grant];
        m_bvalid = grant_oh & {NUM_MST{s_bvalid}};
        m_bid    = {NUM_MST{s_bid}};
        m_bresp  = {NUM_MST{s_bresp}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_oh  <= '0;
      ptr       <= GW'(NUM_MST - 1);
      beat_cnt  <= '0;
      err_wlast <= 1'b0;
      err_bid   <= 1'b0;
    end else begin
      err_wlast <= 1'b0;
      err_bid   <= 1'b0;
      case (state)
        IDLE: if (arb_vld) begin
          grant    <= arb_idx;
          grant_oh <= arb_oh;
          state    <= ADDR;
        end
        ADDR: if (aw_hs) begin
          beat_cnt <= s_awlen;
          state    <= DATA;
        end
        DATA: if (w_hs) begin
          // The burst always ends on wlast; a count disagreement is only reported.
          beat_cnt  <= beat_cnt - LEN_W'(1);
          err_wlast <= s_wlast ^ (beat_cnt == '0);
          if (s_wlast) state <= RESP;
        end
        RESP: if (b_hs) begin
          err_bid <= (s_bid != wid_q);
          ptr     <= grant;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) wid_q <= s_awid;
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter (4 masters) against a transaction-level round-robin model.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int SW  = DW / 8;
  localparam int GW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [N*IDW-1:0]  m_awid, m_bid;
  logic [N*AW-1:0]   m_awaddr;
  logic [N*LW-1:0]   m_awlen;
  logic [N*3-1:0]    m_awsize;
  logic [N*2-1:0]    m_awburst, m_bresp;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic              s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [IDW-1:0]    s_awid, s_wid, s_bid;
  logic [AW-1:0]     s_awaddr;
  logic [LW-1:0]     s_awlen;
  logic [2:0]        s_awsize;
  logic [1:0]        s_awburst, s_bresp;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [GW-1:0]     grant;
  logic              busy, err_wlast, err_bid;

  axi_wr_arbiter #(.NUM_MST(N), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .grant(grant), .busy(busy), .err_wlast(err_wlast), .err_bid(err_bid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ptr_m  = N - 1;
  bit abort  = 1'b0;

  logic [IDW-1:0] id_a   [N];
  logic [AW-1:0]  addr_a [N];
  logic [LW-1:0]  len_a  [N];

  // Reference arbitration: first requester after the last served master, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic any_out();
    return |{m_awready, m_wready, m_bvalid, m_bid, m_bresp, s_awvalid, s_awid, s_awaddr, s_awlen,
             s_awsize, s_awburst, s_wvalid, s_wid, s_wdata, s_wstrb, s_wlast, s_bready,
             grant, busy, err_wlast, err_bid};
  endfunction

  task automatic clear_inputs();
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  task automatic raise(input int i, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len);
    id_a[i] = id; addr_a[i] = addr; len_a[i] = len;
    m_awid[i*IDW +: IDW]  = id;
    m_awaddr[i*AW +: AW]  = addr;
    m_awlen[i*LW +: LW]   = len;
    m_awsize[i*3 +: 3]    = 3'd2;
    m_awburst[i*2 +: 2]   = INCR;
    m_awvalid[i]          = 1'b1;
  endtask

  // One full transaction: the model picks the winner from the raised awvalids and plays master + slave.
  task automatic do_txn(input int nb_delta, input int wr_mode, input logic [IDW-1:0] bid_x,
                        input int rst_beat, output int got_w, output int got_beats);
    int w, b, cyc, nbeats, awlen;
    bit done;
    logic exp_err;
    logic [N-1:0]  oh_w;
    logic [DW-1:0] dq[$];
    logic [SW-1:0] sq[$];
    got_w = -1; got_beats = 0;
    if (abort) return;
    w = rr_pick(m_awvalid, ptr_m);
    if (w < 0) return;
    oh_w = '0; oh_w[w] = 1'b1;
    awlen  = int'(len_a[w]);
    nbeats = awlen + 1 + nb_delta;
    if (nbeats < 1) nbeats = 1;
    for (int i = 0; i < nbeats; i++) begin
      dq.push_back($urandom);
      sq.push_back(SW'($urandom));
    end
    // address phase; first W beat offered early and must stall
    cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      s_awready = ($urandom_range(0, 2) != 0);
      m_wvalid[w] = 1'b1;
      m_wdata[w*DW +: DW] = dq[0];
      m_wstrb[w*SW +: SW] = sq[0];
      m_wlast[w] = (nbeats == 1);
      #1;
      if (cyc == 0) got_w = int'(grant);
      checks++;
      if (grant !== GW'(w) || busy !== 1'b1 || s_awvalid !== 1'b1) begin
        errors++;
        $display("FAIL aw_grant: grant=%0d busy=%b s_awvalid=%b, required grant=%0d busy=1 s_awvalid=1",
                 grant, busy, s_awvalid, w);
      end
      checks++;
      if (s_awid !== id_a[w] || s_awaddr !== addr_a[w] || s_awlen !== len_a[w] || s_awburst !== INCR) begin
        errors++;
        $display("FAIL aw_payload: id=%h addr=%h len=%0d burst=%0d, required id=%h addr=%h len=%0d burst=%0d",
                 s_awid, s_awaddr, s_awlen, s_awburst, id_a[w], addr_a[w], len_a[w], INCR);
      end
      checks++;
      if (m_awready !== (s_awready ? oh_w : '0) || m_wready !== '0 || s_wvalid !== 1'b0) begin
        errors++;
        $display("FAIL aw_ready: m_awready=%b m_wready=%b s_wvalid=%b, required m_awready=%b m_wready=0 s_wvalid=0",
                 m_awready, m_wready, s_wvalid, s_awready ? oh_w : 4'b0);
      end
      if (s_awvalid && s_awready) done = 1'b1;
      if (++cyc > 50) begin
        checks++; errors++; abort = 1'b1;
        $display("FAIL aw_timeout: no AW handshake in 50 cycles, required one");
        return;
      end
    end
    // data phase
    b = 0; exp_err = 1'b0; cyc = 0; done = 1'b0; s_wready = 1'b0;
    while (!done) begin
      @(negedge clk);
      m_awvalid[w] = 1'b0;
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        checks++;
        if (any_out() !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_async: outputs or-reduced=%b, required 0", any_out());
        end
        got_beats = b;
        return;
      end
      case (wr_mode)
        0:       s_wready = 1'b1;
        1:       s_wready = ~s_wready;
        default: s_wready = 1'($urandom_range(0, 1));
      endcase
      m_wvalid[w] = 1'b1;
      m_wdata[w*DW +: DW] = dq[b];
      m_wstrb[w*SW +: SW] = sq[b];
      m_wlast[w] = (b == nbeats - 1);
      #1;
      checks++;
      if (err_wlast !== exp_err) begin
        errors++;
        $display("FAIL err_wlast_data: err_wlast=%b, required %b (beat %0d)", err_wlast, exp_err, b);
      end
      exp_err = 1'b0;
      checks++;
      if (s_wvalid !== 1'b1 || s_wid !== id_a[w] || m_wready !== (s_wready ? oh_w : '0) ||
          s_awvalid !== 1'b0 || grant !== GW'(w)) begin
        errors++;
        $display("FAIL w_ctrl: s_wvalid=%b wid=%h m_wready=%b s_awvalid=%b grant=%0d, required 1 %h %b 0 %0d",
                 s_wvalid, s_wid, m_wready, s_awvalid, grant, id_a[w], s_wready ? oh_w : 4'b0, w);
      end
      if (s_wvalid && s_wready) begin
        checks++;
        if (s_wdata !== dq[b] || s_wstrb !== sq[b] || s_wlast !== (b == nbeats - 1)) begin
          errors++;
          $display("FAIL w_beat%0d: data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                   b, s_wdata, s_wstrb, s_wlast, dq[b], sq[b], b == nbeats - 1);
        end
        exp_err = ((b == nbeats - 1) != (awlen - b == 0));
        b++;
        if (b == nbeats) done = 1'b1;
      end
      if (++cyc > 200) begin
        checks++; errors++; abort = 1'b1;
        $display("FAIL w_timeout: %0d beats taken in 200 cycles, required %0d", b, nbeats);
        return;
      end
    end
    got_beats = b;
    // response phase; a stray W beat stays offered and must not pass
    cyc = 0; done = 1'b0; s_bvalid = 1'b0;
    while (!done) begin
      @(negedge clk);
      m_wvalid[w] = 1'b1;
      m_wlast[w]  = 1'b1;
      if (!s_bvalid) s_bvalid = 1'($urandom_range(0, 1));
      s_bid    = id_a[w] ^ bid_x;
      s_bresp  = $urandom_range(0, 1) ? OKAY : SLVERR;
      m_bready = N'($urandom);
      #1;
      checks++;
      if (err_wlast !== exp_err) begin
        errors++;
        $display("FAIL err_wlast_resp: err_wlast=%b, required %b", err_wlast, exp_err);
      end
      exp_err = 1'b0;
      checks++;
      if (s_wvalid !== 1'b0 || m_wready !== '0 || s_bready !== m_bready[w] ||
          m_bvalid !== (s_bvalid ? oh_w : '0)) begin
        errors++;
        $display("FAIL resp_ctrl: s_wvalid=%b m_wready=%b s_bready=%b m_bvalid=%b, required 0 0 %b %b",
                 s_wvalid, m_wready, s_bready, m_bvalid, m_bready[w], s_bvalid ? oh_w : 4'b0);
      end
      checks++;
      if (m_bid[w*IDW +: IDW] !== s_bid || m_bresp[w*2 +: 2] !== s_bresp) begin
        errors++;
        $display("FAIL resp_payload: bid=%h bresp=%0d, required bid=%h bresp=%0d",
                 m_bid[w*IDW +: IDW], m_bresp[w*2 +: 2], s_bid, s_bresp);
      end
      if (s_bvalid && s_bready) done = 1'b1;
      if (++cyc > 50) begin
        checks++; errors++; abort = 1'b1;
        $display("FAIL b_timeout: no B handshake in 50 cycles, required one");
        return;
      end
    end
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = '0; m_wvalid[w] = 1'b0; m_wlast[w] = 1'b0;
    #1;
    checks++;
    if (err_bid !== (bid_x != '0) || busy !== 1'b0 || s_bready !== 1'b0 || err_wlast !== 1'b0) begin
      errors++;
      $display("FAIL b_done: err_bid=%b busy=%b s_bready=%b err_wlast=%b, required err_bid=%b busy=0 s_bready=0 err_wlast=0",
               err_bid, busy, s_bready, err_wlast, bid_x != '0);
    end
    ptr_m = w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_awvalid = '1; m_wvalid = '1; m_bready = '1; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: or-reduced outputs=%b grant=%0d busy=%b, required all 0", any_out(), grant, busy);
    end
    clear_inputs();
    rst = 1'b0;
    ptr_m = N - 1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b grant=%0d, required busy=0 grant=0", busy, grant);
    end
  endtask

  task automatic test_simultaneous();
    int exp_seq[5] = '{0, 1, 0, 1, 0};
    int gw, nb;
    raise(0, 4'h1, 32'h0000_1000, 4'd1);
    raise(1, 4'h2, 32'h0000_2000, 4'd2);
    for (int t = 0; t < 5; t++) begin
      do_txn(0, 2, '0, -1, gw, nb);
      if (abort) return;
      checks++;
      if (gw !== exp_seq[t]) begin
        errors++;
        $display("FAIL simul_order%0d: grant=%0d, required %0d", t, gw, exp_seq[t]);
      end
      if (t < 3) raise(gw, IDW'(t), 32'h0000_3000 + 32'(t * 64), 4'd1);
    end
  endtask

  task automatic test_single();
    int gw, nb;
    if (abort) return;
    raise(0, 4'h3, 32'h0000_0100, 4'd3);
    do_txn(0, 0, '0, -1, gw, nb);
    checks++;
    if (gw !== 0 || nb !== 4) begin
      errors++;
      $display("FAIL single: grant=%0d beats=%0d, required grant=0 beats=4", gw, nb);
    end
  endtask

  task automatic test_wrap();
    int exp_seq[4] = '{3, 3, 0, 3};
    int gw, nb;
    if (abort) return;
    raise(3, 4'h7, 32'h0000_4000, 4'd0);
    for (int t = 0; t < 4; t++) begin
      if (t == 1) raise(3, 4'h8, 32'h0000_4040, 4'd1);
      if (t == 2) begin
        raise(0, 4'h9, 32'h0000_5000, 4'd2);
        raise(3, 4'hA, 32'h0000_4080, 4'd1);
      end
      do_txn(0, 2, '0, -1, gw, nb);
      if (abort) return;
      checks++;
      if (gw !== exp_seq[t]) begin
        errors++;
        $display("FAIL wrap_order%0d: grant=%0d, required %0d", t, gw, exp_seq[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    int gw, nb;
    if (abort) return;
    raise(2, 4'hB, 32'h0000_6000, 4'd15);
    do_txn(0, 1, '0, -1, gw, nb);
    checks++;
    if (gw !== 2 || nb !== 16) begin
      errors++;
      $display("FAIL backpressure: grant=%0d beats=%0d, required grant=2 beats=16", gw, nb);
    end
  endtask

  task automatic test_wlast_err();
    int gw, nb;
    if (abort) return;
    raise(1, 4'hC, 32'h0000_7000, 4'd3);
    do_txn(-2, 0, '0, -1, gw, nb);
    checks++;
    if (gw !== 1 || nb !== 2) begin
      errors++;
      $display("FAIL wlast_early: grant=%0d beats=%0d, required grant=1 beats=2", gw, nb);
    end
  endtask

  task automatic test_bid_err();
    int gw, nb;
    if (abort) return;
    raise(0, 4'h2, 32'h0000_8000, 4'd1);
    do_txn(0, 0, 4'h7, -1, gw, nb);
    checks++;
    if (gw !== 0 || nb !== 2) begin
      errors++;
      $display("FAIL bid_err_txn: grant=%0d beats=%0d, required grant=0 beats=2", gw, nb);
    end
  endtask

  task automatic test_reset_mid();
    int gw, nb;
    if (abort) return;
    raise(0, 4'h5, 32'h0000_9000, 4'd3);
    do_txn(0, 0, '0, 1, gw, nb);
    if (abort) return;
    @(posedge clk);
    #1;
    checks++;
    if (any_out() !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_edge: or-reduced outputs=%b busy=%b, required 0 0", any_out(), busy);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
    raise(2, 4'h6, 32'h0000_A000, 4'd0);
    raise(1, 4'h4, 32'h0000_B000, 4'd0);
    do_txn(0, 0, '0, -1, gw, nb);
    checks++;
    if (gw !== 1) begin
      errors++;
      $display("FAIL rst_ptr_first: grant=%0d, required 1", gw);
    end
    do_txn(0, 0, '0, -1, gw, nb);
    checks++;
    if (gw !== 2) begin
      errors++;
      $display("FAIL rst_ptr_second: grant=%0d, required 2", gw);
    end
  endtask

  task automatic test_random();
    int gw, nb, dlt;
    logic [IDW-1:0] bx;
    for (int t = 0; t < 40 && !abort; t++) begin
      for (int i = 0; i < N; i++)
        if (!m_awvalid[i] && $urandom_range(0, 1))
          raise(i, IDW'($urandom), $urandom, LW'($urandom));
      if (m_awvalid == '0) raise($urandom_range(0, N - 1), IDW'($urandom), $urandom, LW'($urandom));
      dlt = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 1 : -1) : 0;
      bx  = ($urandom_range(0, 5) == 0) ? IDW'($urandom_range(1, 15)) : '0;
      do_txn(dlt, $urandom_range(0, 2), bx, -1, gw, nb);
    end
    while (m_awvalid != '0 && !abort) do_txn(0, 2, '0, -1, gw, nb);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_wrap();
    test_backpressure();
    test_wlast_err();
    test_bid_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
